// File: rtl/sa_input_feeder.sv
// Systolic-array input feeder: diagonal skew, token-tracked column valids and automatic zero flush.
// Optional macro SA_INPUT_FEEDER_BUBBLE_EN: keep advancing with zero bubbles during STREAM input gaps.
module sa_input_feeder #(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]       in_data,
  input  logic                                          in_last,
  input  logic                                          out_ready,
  output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]       sa_inputs,
  output logic                                          sa_advance,
  output logic [SA_SIZE-1:0]                            col_valid,
  output logic                                          busy,
  output logic                                          done
);

  localparam int TOK_LEN   = 2*SA_SIZE - 1;
  localparam int FLUSH_LEN = 2*SA_SIZE - 2;
  localparam int CNT_W     = $clog2(TOK_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TOK_LEN-1:1]   tok_q, tok_d;
  logic                 accept;
  logic                 bubble;
  logic                 flush_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tok_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tok_q   <= tok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    bubble    = 1'b0;
    flush_adv = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE:   in_ready = out_ready & ~reset;
      S_STREAM: begin
        in_ready = out_ready & ~reset;
`ifdef SA_INPUT_FEEDER_BUBBLE_EN
        bubble   = out_ready & ~in_valid & ~reset;
`else
        bubble   = 1'b0;
`endif
      end
      S_FLUSH:  flush_adv = out_ready & ~reset;
      default:  state_d = S_IDLE;
    endcase

    accept = in_valid & in_ready;
    if (accept) begin
      state_d = in_last ? S_FLUSH : S_STREAM;
      if (in_last) cnt_d = '0;
    end

    // The last flush advance carries the final vector's last column out of the array.
    if (flush_adv) begin
      if (cnt_q == CNT_LAST) begin
        done    = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    sa_advance = accept | flush_adv | bubble;
    busy       = (state_q != S_IDLE);
    tok_d      = sa_advance ? {tok_q[TOK_LEN-2:1], accept} : tok_q;
  end

  assign sa_inputs[0] = accept ? in_data[0] : '0;

  for (genvar c = 0; c < SA_SIZE; c++) begin : g_col
    assign col_valid[c] = sa_advance & tok_q[SA_SIZE-1+c];
  end

  // Row r is an r-deep chain that only shifts when the array advances.
  for (genvar r = 1; r < SA_SIZE; r++) begin : g_row
    logic [ACTIVATION_SIZE-1:0] chain_q [r];
    logic [ACTIVATION_SIZE-1:0] chain_d [r];

    always_comb begin
      chain_d = chain_q;
      if (sa_advance) begin
        chain_d[0] = accept ? in_data[r] : '0;
        for (int s = 1; s < r; s++) chain_d[s] = chain_q[s-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < r; s++) chain_q[s] <= '0;
      end else begin
        chain_q <= chain_d;
      end
    end

    assign sa_inputs[r] = sa_advance ? chain_q[r-1] : '0;
  end

endmodule

// File: tb/tb_sa_input_feeder.sv
// Scoreboard bench for sa_input_feeder: a per-cycle predictor built on advance numbering
// pushes expected outputs; a monitor pops and compares them against the DUT.
module tb_sa_input_feeder;
  localparam int N = 4;
  localparam int A = 8;
`ifdef SA_INPUT_FEEDER_BUBBLE_EN
  localparam bit BUBBLE = 1'b1;
`else
  localparam bit BUBBLE = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0][A-1:0]   in_data;
  logic                  in_last;
  logic                  out_ready;
  logic [N-1:0][A-1:0]   sa_inputs;
  logic                  sa_advance;
  logic [N-1:0]          col_valid;
  logic                  busy;
  logic                  done;

  sa_input_feeder #(.SA_SIZE(N), .ACTIVATION_SIZE(A)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_ready  (out_ready),
    .sa_inputs  (sa_inputs),
    .sa_advance (sa_advance),
    .col_valid  (col_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                adv;
    logic                rdy;
    logic                busy;
    logic                done;
    logic [N-1:0]        cv;
    logic [N-1:0][A-1:0] si;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: vectors indexed by the advance number at which they were accepted.
  logic [N-1:0][A-1:0] acc_map [int];
  int adv_cnt    = 0;
  int flush_left = 0;
  bit in_job     = 0;

  always @(negedge clk) begin
    exp_t e;
    bit acc, bub;
    e = '0;
    if (reset) begin
      acc_map.delete();
      adv_cnt    = 0;
      flush_left = 0;
      in_job     = 0;
    end else begin
      e.rdy  = out_ready && (flush_left == 0);
      acc    = in_valid && e.rdy;
      bub    = BUBBLE && in_job && (flush_left == 0) && out_ready && !in_valid;
      e.adv  = acc || (flush_left > 0 && out_ready) || bub;
      e.busy = in_job || (flush_left > 0);
      if (acc) acc_map[adv_cnt] = in_data;
      if (e.adv) begin
        for (int r = 0; r < N; r++)
          if (acc_map.exists(adv_cnt - r)) e.si[r] = acc_map[adv_cnt - r][r];
        for (int c = 0; c < N; c++)
          e.cv[c] = acc_map.exists(adv_cnt - (N - 1) - c);
        e.done = (flush_left == 1) && out_ready;
        adv_cnt++;
      end
      if (acc) begin
        if (in_last) begin
          flush_left = 2*N - 2;
          in_job     = 0;
        end else begin
          in_job = 1;
        end
      end else if (flush_left > 0 && out_ready) begin
        flush_left--;
      end
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sa_advance", 64'(sa_advance), 64'(e.adv));
      chk("in_ready",   64'(in_ready),   64'(e.rdy));
      chk("busy",       64'(busy),       64'(e.busy));
      chk("done",       64'(done),       64'(e.done));
      chk("col_valid",  64'(col_valid),  64'(e.cv));
      chk("sa_inputs",  64'(sa_inputs),  64'(e.si));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0][A-1:0] d, input logic last);
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout @%0t: got no accept expected accept within 64 cycles", $time);
    end
  endtask

  function automatic logic [N-1:0][A-1:0] vec(input int base);
    logic [N-1:0][A-1:0] v;
    for (int r = 0; r < N; r++) v[r] = A'(base + r);
    return v;
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    send(vec(1), 1'b1);
    cyc(10);

    send(vec(10), 1'b0);
    send(vec(20), 1'b0);
    send(vec(30), 1'b1);
    cyc(12);

    send(vec(40), 1'b1);
    cyc(2);
    out_ready = 1'b0;
    cyc(5);
    out_ready = 1'b1;
    cyc(10);

    send(vec(50), 1'b0);
    send(vec(60), 1'b0);
    cyc(3);
    send(vec(70), 1'b1);
    cyc(12);

    send(vec(80), 1'b1);
    cyc(3);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    send(vec(1), 1'b1);
    cyc(10);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = vec(90);
    in_last   = 1'b1;
    cyc(3);
    out_ready = 1'b1;
    send(vec(90), 1'b1);
    cyc(10);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_last   = ($urandom_range(0, 99) < 20);
      out_ready = ($urandom_range(0, 99) < 75);
      for (int r = 0; r < N; r++) in_data[r] = A'($urandom);
      reset     = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
